alu_op_decoder: RTL and testbench
=================================

Name: alu_op_decoder

Overview:
- Decode stage that feeds the ALU. Accepts a 32-bit MIPS32 instruction plus its two register-file read values, and produces OPERATOR, OPERAND1, OPERAND2 and write-back control.
- Pipelined with valid/ready handshakes on both sides. A 2-entry skid buffer keeps IN_READY registered, so there is no combinational path from OUT_READY to IN_READY.
- Sits between instruction fetch/register read and the ALU. It is the producer end of the ALU's OPERATOR/OPERAND interface.

Parameters:
- WORD_LEN, 32, width of instruction, operands and register data
- OPERATOR_LEN, 4, width of the operator code; codes are the `OPERATOR_*` values from defines.v
- REG_ADDR_LEN, 5, register index width

Ports:
- CLK  in  1  clock, all state on posedge
- RST  in  1  asynchronous, active-high reset
- IN_VALID  in  1  instruction/data valid
- IN_READY  out  1  decoder can accept; registered output
- INSTR  in  WORD_LEN  instruction word
- RS_DATA  in  WORD_LEN  register-file value of rs
- RT_DATA  in  WORD_LEN  register-file value of rt
- OUT_VALID  out  1  decoded bundle valid
- OUT_READY  in  1  ALU stage accepts bundle
- OPERATOR  out  OPERATOR_LEN  ALU operation
- OPERAND1  out  WORD_LEN  first ALU operand
- OPERAND2  out  WORD_LEN  second ALU operand
- DEST_REG  out  REG_ADDR_LEN  write-back register index
- WB_EN  out  1  write-back enable
- ILLEGAL  out  1  instruction not in the decode table

Behaviour:
- Handshakes:
  - Transfer in on IN_VALID & IN_READY; transfer out on OUT_VALID & OUT_READY.
  - OUT_VALID holds and the bundle is stable until accepted.
- Latency: 1 cycle. A bundle accepted at edge N is presented with OUT_VALID=1 after edge N when the output register is free.
- Output register plus one skid entry; occupancy 0..2:
  - IN_READY = (occupancy < 2) after each edge.
  - When the output is accepted and the skid is full, the skid moves to output on the same edge.
  - When the input is accepted on that same edge, it lands in the skid.
  - Simultaneous in/out at occupancy 1: the output is replaced by the new entry; occupancy stays 1.
  - Input offered at occupancy 2 is not accepted (IN_READY=0); no loss, no duplication.
- Decode, R-type (opcode 0x00), selected by funct:
  - 0x20 ADD, 0x22 SUB, 0x24 AND, 0x25 OR, 0x26 XOR, 0x27 NOR: OPERAND1=RS_DATA, OPERAND2=RT_DATA, DEST_REG=rd.
  - 0x00 SLL, 0x02 SRL, 0x03 SRA: OPERAND1=RT_DATA, OPERAND2=zero-extended shamt, DEST_REG=rd.
- Decode, I-type (OPERAND1=RS_DATA, DEST_REG=rt unless stated):
  - 0x08 ADDI → ADD, sign-extended imm16.
  - 0x0C ANDI, 0x0D ORI, 0x0E XORI: zero-extended imm16.
  - 0x23 LW → ADD, sign-extended imm16, WB_EN=1.
  - 0x2B SW → ADD, sign-extended imm16, WB_EN=0, DEST_REG=0.
- Write-back: WB_EN=1 for every legal op except SW. Forced to 0 when DEST_REG==0, so 0x00000000 decodes as SLL with WB_EN=0.
- Anything else:
  - OPERATOR=`OPERATOR_NOP`, OPERAND1=OPERAND2=0, DEST_REG=0, WB_EN=0, ILLEGAL=1.
  - The bundle still flows through the pipeline.
- Reset, asynchronous:
  - OUT_VALID=0, occupancy=0, IN_READY=1 after release.
  - OPERATOR=`OPERATOR_NOP`; OPERAND1, OPERAND2, DEST_REG, WB_EN and ILLEGAL all 0.
  - Reset mid-transfer discards both entries.
  - IN_READY is 0 while RST is high.

Optional Feature:
- Macro: ALU_DECODER_ILLEGAL_CNT_EN.
- Defined:
  - Extra output port ILLEGAL_CNT [15:0].
  - Increments on each output transfer with ILLEGAL=1.
  - Saturates at 0xFFFF; cleared by RST.
- Undefined: port and counter absent; all other behaviour identical.

Test Plan:
- Reset: assert RST mid-stream with 2 entries buffered → OUT_VALID=0, OPERATOR=`OPERATOR_NOP`, IN_READY=1 one cycle after release; no stale bundle emerges.
- R-type ADD:
  - Stimulus: INSTR=0x01095020 (add $10,$8,$9), RS_DATA=5, RT_DATA=7, OUT_READY=1.
  - Required next cycle: OPERATOR=`OPERATOR_ADD`, OPERAND1=5, OPERAND2=7, DEST_REG=10, WB_EN=1.
- Immediates:
  - ADDI 0x2128FFFF with RS_DATA=3 → OPERAND2=0xFFFFFFFF, DEST_REG=8.
  - ORI 0x3528FFFF → OPERAND2=0x0000FFFF, OPERATOR=`OPERATOR_OR`.
- Shift and NOP:
  - SRA 0x00084103, RT_DATA=0x80000000 → OPERAND1=0x80000000, OPERAND2=4, DEST_REG=8.
  - INSTR=0x00000000 → WB_EN=0, ILLEGAL=0.
- Backpressure:
  - Stimulus: stream 4 back-to-back instructions with OUT_READY=0 for 3 cycles.
  - Required: IN_READY falls after 2 accepts; the 4 bundles emerge in order without loss or duplication after OUT_READY=1; OUT_VALID outputs stay stable while stalled.
- Illegal, with ALU_DECODER_ILLEGAL_CNT_EN defined:
  - Stimulus: INSTR=0xFC000000.
  - Required: ILLEGAL=1, OPERATOR=`OPERATOR_NOP`, WB_EN=0, ILLEGAL_CNT 0→1.
  - With the counter preloaded to 0xFFFF, a further illegal transfer leaves it at 0xFFFF.

Source files
------------

// File: rtl/alu_op_decoder.sv
// MIPS32 decode stage feeding the ALU: registered output plus one skid entry.
// Optional macro ALU_DECODER_ILLEGAL_CNT_EN adds a saturating ILLEGAL_CNT output.

`ifndef OPERATOR_NOP
`define OPERATOR_NOP 4'd0
`define OPERATOR_ADD 4'd1
`define OPERATOR_SUB 4'd2
`define OPERATOR_AND 4'd3
`define OPERATOR_OR  4'd4
`define OPERATOR_XOR 4'd5
`define OPERATOR_NOR 4'd6
`define OPERATOR_SLL 4'd7
`define OPERATOR_SRL 4'd8
`define OPERATOR_SRA 4'd9
`endif

module alu_op_decoder #(
    parameter int WORD_LEN     = 32,
    parameter int OPERATOR_LEN = 4,
    parameter int REG_ADDR_LEN = 5
) (
    input  logic                    CLK,
    input  logic                    RST,
    input  logic                    IN_VALID,
    output logic                    IN_READY,
    input  logic [WORD_LEN-1:0]     INSTR,
    input  logic [WORD_LEN-1:0]     RS_DATA,
    input  logic [WORD_LEN-1:0]     RT_DATA,
    output logic                    OUT_VALID,
    input  logic                    OUT_READY,
    output logic [OPERATOR_LEN-1:0] OPERATOR,
    output logic [WORD_LEN-1:0]     OPERAND1,
    output logic [WORD_LEN-1:0]     OPERAND2,
    output logic [REG_ADDR_LEN-1:0] DEST_REG,
    output logic                    WB_EN,
    output logic                    ILLEGAL
`ifdef ALU_DECODER_ILLEGAL_CNT_EN
    ,
    output logic [15:0]             ILLEGAL_CNT
`endif
);

    typedef struct packed {
        logic [OPERATOR_LEN-1:0] op;
        logic [WORD_LEN-1:0]     a;
        logic [WORD_LEN-1:0]     b;
        logic [REG_ADDR_LEN-1:0] dest;
        logic                    wb;
        logic                    ill;
    } bundle_t;

    function automatic bundle_t decode(
        input logic [5:0]          opcode,
        input logic [5:0]          funct,
        input logic [4:0]          rt,
        input logic [4:0]          rd,
        input logic [4:0]          shamt,
        input logic [15:0]         imm,
        input logic [WORD_LEN-1:0] rs_data,
        input logic [WORD_LEN-1:0] rt_data
    );
        bundle_t d;
        logic    legal;
        logic [WORD_LEN-1:0] imm_sx;
        logic [WORD_LEN-1:0] imm_zx;
        imm_sx = {{(WORD_LEN-16){imm[15]}}, imm};
        imm_zx = {{(WORD_LEN-16){1'b0}}, imm};
        d      = '0;
        d.op   = OPERATOR_LEN'(`OPERATOR_NOP);
        d.a    = rs_data;
        d.dest = REG_ADDR_LEN'(rt);
        d.wb   = 1'b1;
        legal  = 1'b1;
        case (opcode)
            6'h00: begin
                d.dest = REG_ADDR_LEN'(rd);
                d.b    = rt_data;
                case (funct)
                    6'h20: d.op = OPERATOR_LEN'(`OPERATOR_ADD);
                    6'h22: d.op = OPERATOR_LEN'(`OPERATOR_SUB);
                    6'h24: d.op = OPERATOR_LEN'(`OPERATOR_AND);
                    6'h25: d.op = OPERATOR_LEN'(`OPERATOR_OR);
                    6'h26: d.op = OPERATOR_LEN'(`OPERATOR_XOR);
                    6'h27: d.op = OPERATOR_LEN'(`OPERATOR_NOR);
                    6'h00, 6'h02, 6'h03: begin
                        // Shifts operate on rt by the instruction's shamt field.
                        d.a = rt_data;
                        d.b = WORD_LEN'(shamt);
                        d.op = (funct == 6'h00) ? OPERATOR_LEN'(`OPERATOR_SLL) :
                               (funct == 6'h02) ? OPERATOR_LEN'(`OPERATOR_SRL) :
                                                  OPERATOR_LEN'(`OPERATOR_SRA);
                    end
                    default: legal = 1'b0;
                endcase
            end
            6'h08, 6'h23: begin d.op = OPERATOR_LEN'(`OPERATOR_ADD); d.b = imm_sx; end
            6'h0C: begin d.op = OPERATOR_LEN'(`OPERATOR_AND); d.b = imm_zx; end
            6'h0D: begin d.op = OPERATOR_LEN'(`OPERATOR_OR);  d.b = imm_zx; end
            6'h0E: begin d.op = OPERATOR_LEN'(`OPERATOR_XOR); d.b = imm_zx; end
            6'h2B: begin
                d.op   = OPERATOR_LEN'(`OPERATOR_ADD);
                d.b    = imm_sx;
                d.dest = '0;
                d.wb   = 1'b0;
            end
            default: legal = 1'b0;
        endcase
        if (d.dest == '0) d.wb = 1'b0;
        if (!legal) begin
            d     = '0;
            d.op  = OPERATOR_LEN'(`OPERATOR_NOP);
            d.ill = 1'b1;
        end
        return d;
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    bundle_t dec_p0;
    bundle_t out_p1;
    bundle_t skid_p1;
    logic    out_valid_p1, skid_valid_p1, in_ready_p1;
    logic    out_valid_n, skid_valid_n;
    logic    load_out_dec, load_out_skid, load_skid;
    logic    accept_in, accept_out;
    logic    unused_rs_field;

    assign unused_rs_field = ^INSTR[25:21];

    // Stage p0: combinational decode of the incoming instruction
    assign dec_p0 = decode(INSTR[31:26], INSTR[5:0], INSTR[20:16], INSTR[15:11],
                           INSTR[10:6], INSTR[15:0], RS_DATA, RT_DATA);

    assign accept_in  = IN_VALID & in_ready_p1;
    assign accept_out = out_valid_p1 & OUT_READY;

    always_comb begin
        out_valid_n   = out_valid_p1;
        skid_valid_n  = skid_valid_p1;
        load_out_dec  = 1'b0;
        load_out_skid = 1'b0;
        load_skid     = 1'b0;
        if (accept_out) begin
            if (skid_valid_p1) begin
                load_out_skid = 1'b1;
                if (accept_in) load_skid = 1'b1;
                else           skid_valid_n = 1'b0;
            end else if (accept_in) begin
                load_out_dec = 1'b1;
            end else begin
                out_valid_n = 1'b0;
            end
        end else if (accept_in) begin
            if (!out_valid_p1) begin
                load_out_dec = 1'b1;
                out_valid_n  = 1'b1;
            end else begin
                load_skid    = 1'b1;
                skid_valid_n = 1'b1;
            end
        end
    end

    // Stage p1: output register, skid entry and registered ready
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_valid_p1  <= 1'b0;
            skid_valid_p1 <= 1'b0;
            in_ready_p1   <= 1'b0;
        end else begin
            out_valid_p1  <= out_valid_n;
            skid_valid_p1 <= skid_valid_n;
            in_ready_p1   <= ~skid_valid_n;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_p1    <= '0;
            out_p1.op <= OPERATOR_LEN'(`OPERATOR_NOP);
        end else if (load_out_dec) begin
            out_p1 <= dec_p0;
        end else if (load_out_skid) begin
            out_p1 <= skid_p1;
        end
    end

    always_ff @(posedge CLK) begin
        if (load_skid) skid_p1 <= dec_p0;
    end

`ifdef ALU_DECODER_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt_p1;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) illegal_cnt_p1 <= '0;
        else if (accept_out && out_p1.ill) illegal_cnt_p1 <= sat_inc(illegal_cnt_p1);
    end

    assign ILLEGAL_CNT = illegal_cnt_p1;
`else
    logic [15:0] unused_sat_probe;
    assign unused_sat_probe = sat_inc(16'h0000);
`endif

    assign IN_READY  = in_ready_p1;
    assign OUT_VALID = out_valid_p1;
    assign OPERATOR  = out_p1.op;
    assign OPERAND1  = out_p1.a;
    assign OPERAND2  = out_p1.b;
    assign DEST_REG  = out_p1.dest;
    assign WB_EN     = out_p1.wb;
    assign ILLEGAL   = out_p1.ill;

endmodule

// File: tb/tb_alu_op_decoder.sv
// Directed self-checking bench for alu_op_decoder: decode table, backpressure, reset,
// and (with ALU_DECODER_ILLEGAL_CNT_EN) the saturating illegal counter.

`ifndef OPERATOR_NOP
`define OPERATOR_NOP 4'd0
`define OPERATOR_ADD 4'd1
`define OPERATOR_SUB 4'd2
`define OPERATOR_AND 4'd3
`define OPERATOR_OR  4'd4
`define OPERATOR_XOR 4'd5
`define OPERATOR_NOR 4'd6
`define OPERATOR_SLL 4'd7
`define OPERATOR_SRL 4'd8
`define OPERATOR_SRA 4'd9
`endif

module tb_alu_op_decoder;

    logic        clk = 1'b0;
    logic        rst, in_valid, in_ready, out_valid, out_ready, wb_en, illegal;
    logic [31:0] instr, rs_data, rt_data, operand1, operand2;
    logic [3:0]  operator;
    logic [4:0]  dest_reg;
`ifdef ALU_DECODER_ILLEGAL_CNT_EN
    logic [15:0] illegal_cnt;
`endif
    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    alu_op_decoder dut (
        .CLK(clk), .RST(rst), .IN_VALID(in_valid), .IN_READY(in_ready),
        .INSTR(instr), .RS_DATA(rs_data), .RT_DATA(rt_data),
        .OUT_VALID(out_valid), .OUT_READY(out_ready),
        .OPERATOR(operator), .OPERAND1(operand1), .OPERAND2(operand2),
        .DEST_REG(dest_reg), .WB_EN(wb_en), .ILLEGAL(illegal)
`ifdef ALU_DECODER_ILLEGAL_CNT_EN
        , .ILLEGAL_CNT(illegal_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam int NV = 15;
    logic [31:0] v_instr [NV];
    logic [31:0] v_rs    [NV];
    logic [31:0] v_rt    [NV];
    logic [3:0]  v_op    [NV];
    logic [31:0] v_a     [NV];
    logic [31:0] v_b     [NV];
    logic [4:0]  v_dest  [NV];
    logic        v_wb    [NV];
    logic        v_ill   [NV];

    initial begin
        //            instr          rs            rt
        v_instr = '{32'h01095020, 32'h2128FFFF, 32'h3528FFFF, 32'h00084103, 32'h00000000,
                    32'h00221822, 32'h38C58001, 32'h8FA7FFFC, 32'hAFA70008, 32'h01095001,
                    32'hFC000000, 32'h000227C2, 32'h00200827, 32'h20200005, 32'h00641024};
        v_rs    = '{32'd5, 32'd3, 32'h12340000, 32'h11, 32'd9,
                    32'd10, 32'hFFFF0000, 32'h1000, 32'h1000, 32'h77,
                    32'h88, 32'h99, 32'hA5A5A5A5, 32'h40, 32'hF0F0F0F0};
        v_rt    = '{32'd7, 32'd0, 32'd0, 32'h80000000, 32'hABCD,
                    32'd4, 32'd1, 32'd2, 32'hDEAD, 32'h66,
                    32'h55, 32'hF0, 32'h0000FFFF, 32'h3, 32'h0FF00FF0};
        v_op    = '{`OPERATOR_ADD, `OPERATOR_ADD, `OPERATOR_OR,  `OPERATOR_SRA, `OPERATOR_SLL,
                    `OPERATOR_SUB, `OPERATOR_XOR, `OPERATOR_ADD, `OPERATOR_ADD, `OPERATOR_NOP,
                    `OPERATOR_NOP, `OPERATOR_SRL, `OPERATOR_NOR, `OPERATOR_ADD, `OPERATOR_AND};
        v_a     = '{32'd5, 32'd3, 32'h12340000, 32'h80000000, 32'hABCD,
                    32'd10, 32'hFFFF0000, 32'h1000, 32'h1000, 32'd0,
                    32'd0, 32'hF0, 32'hA5A5A5A5, 32'h40, 32'hF0F0F0F0};
        v_b     = '{32'd7, 32'hFFFFFFFF, 32'h0000FFFF, 32'd4, 32'd0,
                    32'd4, 32'h00008001, 32'hFFFFFFFC, 32'd8, 32'd0,
                    32'd0, 32'd31, 32'h0000FFFF, 32'd5, 32'h0FF00FF0};
        v_dest  = '{5'd10, 5'd8, 5'd8, 5'd8, 5'd0, 5'd3, 5'd5, 5'd7, 5'd0, 5'd0,
                    5'd0, 5'd4, 5'd1, 5'd0, 5'd2};
        v_wb    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0,
                    1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        v_ill   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1,
                    1'b1, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        instr = '0; rs_data = '0; rt_data = '0;

        // Reset state
        step();
        chk("rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst operator", {28'd0, operator}, {28'd0, `OPERATOR_NOP});
        chk("rst operands", operand1 | operand2, 32'd0);
        chk("rst dest/wb/ill", {25'd0, dest_reg, wb_en, illegal}, 32'd0);
`ifdef ALU_DECODER_ILLEGAL_CNT_EN
        chk("rst illegal_cnt", {16'd0, illegal_cnt}, 32'd0);
`endif
        rst = 1'b0;
        step();
        chk("post-rst in_ready", {31'd0, in_ready}, 32'd1);
        chk("post-rst out_valid", {31'd0, out_valid}, 32'd0);

        // Decode table, streamed back-to-back with the ALU always ready
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int i = 0; i < NV; i++) begin
            instr = v_instr[i]; rs_data = v_rs[i]; rt_data = v_rt[i];
            step();
            chk($sformatf("vec%0d valid", i), {31'd0, out_valid}, 32'd1);
            chk($sformatf("vec%0d in_ready", i), {31'd0, in_ready}, 32'd1);
            chk($sformatf("vec%0d op", i), {28'd0, operator}, {28'd0, v_op[i]});
            chk($sformatf("vec%0d operand1", i), operand1, v_a[i]);
            chk($sformatf("vec%0d operand2", i), operand2, v_b[i]);
            chk($sformatf("vec%0d dest", i), {27'd0, dest_reg}, {27'd0, v_dest[i]});
            chk($sformatf("vec%0d wb_en", i), {31'd0, wb_en}, {31'd0, v_wb[i]});
            chk($sformatf("vec%0d illegal", i), {31'd0, illegal}, {31'd0, v_ill[i]});
`ifdef ALU_DECODER_ILLEGAL_CNT_EN
            if (i == 10) chk("cnt after first illegal", {16'd0, illegal_cnt}, 32'd1);
`endif
        end
        in_valid = 1'b0;
        step();
        chk("drain out_valid", {31'd0, out_valid}, 32'd0);
`ifdef ALU_DECODER_ILLEGAL_CNT_EN
        chk("cnt after table", {16'd0, illegal_cnt}, 32'd2);
`endif

        // Backpressure: four ADDs tagged by rs_data, ALU stalled for three edges
        instr = 32'h01095020; rt_data = 32'd0;
        out_ready = 1'b0; in_valid = 1'b1; rs_data = 32'h101;
        step();
        chk("bp e1 valid", {31'd0, out_valid}, 32'd1);
        chk("bp e1 op1", operand1, 32'h101);
        chk("bp e1 in_ready", {31'd0, in_ready}, 32'd1);
        rs_data = 32'h102;
        step();
        chk("bp e2 in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp e2 op1 stable", operand1, 32'h101);
        rs_data = 32'h103;
        step();
        chk("bp e3 in_ready", {31'd0, in_ready}, 32'd0);
        chk("bp e3 valid", {31'd0, out_valid}, 32'd1);
        chk("bp e3 op1 stable", operand1, 32'h101);
        out_ready = 1'b1;
        step();
        chk("bp e4 op1", operand1, 32'h102);
        chk("bp e4 in_ready", {31'd0, in_ready}, 32'd1);
        step();
        chk("bp e5 op1", operand1, 32'h103);
        rs_data = 32'h104;
        step();
        chk("bp e6 op1", operand1, 32'h104);
        chk("bp e6 valid", {31'd0, out_valid}, 32'd1);
        in_valid = 1'b0;
        step();
        chk("bp e7 valid", {31'd0, out_valid}, 32'd0);

        // Reset with both entries occupied
        out_ready = 1'b0; in_valid = 1'b1; rs_data = 32'h55;
        step();
        rs_data = 32'h66;
        step();
        chk("mid full in_ready", {31'd0, in_ready}, 32'd0);
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid rst out_valid", {31'd0, out_valid}, 32'd0);
        chk("mid rst in_ready", {31'd0, in_ready}, 32'd0);
        chk("mid rst operator", {28'd0, operator}, {28'd0, `OPERATOR_NOP});
        chk("mid rst operand1", operand1, 32'd0);
        step();
        rst = 1'b0;
        step();
        chk("mid post in_ready", {31'd0, in_ready}, 32'd1);
        chk("mid post out_valid", {31'd0, out_valid}, 32'd0);
        out_ready = 1'b1;
        step();
        step();
        chk("mid no stale", {31'd0, out_valid}, 32'd0);

`ifdef ALU_DECODER_ILLEGAL_CNT_EN
        // Counter saturation
        chk("cnt cleared", {16'd0, illegal_cnt}, 32'd0);
        instr = 32'hFC000000; in_valid = 1'b1; out_ready = 1'b1;
        for (int k = 0; k < 65534; k++) step();
        in_valid = 1'b0;
        step();
        chk("cnt 0xFFFE", {16'd0, illegal_cnt}, 32'h0000FFFE);
        in_valid = 1'b1; step(); in_valid = 1'b0; step();
        chk("cnt 0xFFFF", {16'd0, illegal_cnt}, 32'h0000FFFF);
        in_valid = 1'b1; step(); in_valid = 1'b0; step();
        chk("cnt saturated", {16'd0, illegal_cnt}, 32'h0000FFFF);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
